// File: rtl/cla_result_checker.sv
// Response checker for the carry-lookahead adder: captures operands on valid_in,
// waits the adder latency, samples S against the golden sum and keeps running counts.
module cla_result_checker #(
    parameter int WIDTH   = 4,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             c0,
    input  logic [WIDTH:0]   S,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH:0]   expected,
    output logic [7:0]       chk_count,
    output logic [7:0]       err_count,
    output logic             overrun
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [3:0] LAT_LOAD = 4'(LATENCY);

    state_t         state_r;
    logic [3:0]     cnt_r;
    logic [WIDTH:0] sum_s;
    logic           match_s;
    logic [7:0]     chk_next_s;
    logic [7:0]     err_next_s;

    // Full-width sum so the adder's carry-out lands in the MSB.
    function automatic logic [WIDTH:0] golden_sum(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic             ci);
        return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
    endfunction

    // Golden sum, compare result and saturating count increments.
    always_comb begin
        sum_s      = golden_sum(A, B, c0);
        match_s    = (S == expected);
        chk_next_s = chk_count;
        err_next_s = err_count;
        if (chk_count != 8'd255) begin
            chk_next_s = chk_count + 8'd1;
        end else begin
            chk_next_s = chk_count;
        end
        if (err_count != 8'd255) begin
            err_next_s = err_count + 8'd1;
        end else begin
            err_next_s = err_count;
        end
    end

    // Capture / wait / sample sequencer with registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            expected  <= {(WIDTH+1){1'b0}};
            chk_count <= 8'd0;
            err_count <= 8'd0;
            overrun   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (valid_in) begin
                        expected <= sum_s;
                        cnt_r    <= LAT_LOAD;
                        busy     <= 1'b1;
                        state_r  <= WAIT;
                    end
                end
                WAIT: begin
                    // Operands offered mid-check are dropped; only the flag records it.
                    if (valid_in) begin
                        overrun <= 1'b1;
                    end
                    if (cnt_r == 4'd1) begin
                        pass      <= match_s;
                        chk_count <= chk_next_s;
                        if (!match_s) begin
                            err_count <= err_next_s;
                        end
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        cnt_r   <= 4'd0;
                        state_r <= IDLE;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    cnt_r   <= 4'd0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla_result_checker.sv
// Bench for cla_result_checker: directed scenarios plus random traffic, all
// compared each cycle against a cycle-indexed transaction model.
module tb_cla_result_checker;

    localparam int W = 4;
    localparam int L = 2;

    logic         clk;
    logic         rst;
    logic         valid_in;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         c0;
    logic [W:0]   S;
    logic         busy;
    logic         done;
    logic         pass;
    logic [W:0]   expected;
    logic [7:0]   chk_count;
    logic [7:0]   err_count;
    logic         overrun;

    cla_result_checker #(.WIDTH(W), .LATENCY(L)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .A(A), .B(B), .c0(c0), .S(S),
        .busy(busy), .done(done), .pass(pass), .expected(expected),
        .chk_count(chk_count), .err_count(err_count), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic checking = 1'b0;
    logic force_err = 1'b0;

    function automatic logic [W:0] add(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic ci);
        return 5'(a) + 5'(b) + 5'(ci);
    endfunction

    // Stand-in adder: two register stages, LSB optionally corrupted.
    logic [W:0] st1, st2;
    always @(posedge clk) begin
        st1 <= add(A, B, c0);
        st2 <= st1;
    end
    assign S = st2 ^ {4'b0000, force_err};

    // Transaction model: a check accepted at cycle c resolves at cycle c+L.
    int         cyc = 0;
    int         m_due;
    logic       m_busy, m_done, m_pass, m_ovr;
    logic [W:0] m_exp;
    int         m_chk, m_err;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_pass <= 1'b0; m_ovr <= 1'b0;
            m_exp <= '0; m_chk <= 0; m_err <= 0; m_due <= 0;
        end else begin
            cyc <= cyc + 1;
            m_done <= 1'b0;
            if (!m_busy) begin
                if (valid_in) begin
                    m_exp  <= add(A, B, c0);
                    m_due  <= cyc + L;
                    m_busy <= 1'b1;
                end
            end else begin
                if (valid_in) m_ovr <= 1'b1;
                if (cyc == m_due) begin
                    m_pass <= (S == m_exp);
                    m_chk  <= (m_chk < 255) ? m_chk + 1 : 255;
                    if (S != m_exp) m_err <= (m_err < 255) ? m_err + 1 : 255;
                    m_done <= 1'b1;
                    m_busy <= 1'b0;
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (checking && !rst) begin
            check("m_busy", busy, m_busy);
            check("m_done", done, m_done);
            check("m_pass", pass, m_pass);
            check("m_expected", expected, m_exp);
            check("m_chk_count", chk_count, m_chk);
            check("m_err_count", err_count, m_err);
            check("m_overrun", overrun, m_ovr);
        end
    end

    task automatic txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                       input logic f);
        int n;
        @(negedge clk);
        A = a; B = b; c0 = ci; valid_in = 1'b1; force_err = f;
        @(negedge clk);
        valid_in = 1'b0; A = W'($urandom); B = W'($urandom); c0 = 1'($urandom);
        n = 0;
        while (!done && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("txn_done_seen", done, 1'b1);
        force_err = 1'b0;
    endtask

    int dones;

    initial begin
        rst = 1'b1; valid_in = 1'b0; A = '0; B = '0; c0 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_expected", expected, 5'd0);
        check("rst_chk", chk_count, 8'd0);
        check("rst_overrun", overrun, 1'b0);
        rst = 1'b0;
        checking = 1'b1;

        // Directed, hand-computed
        txn(4'b0001, 4'b0010, 1'b1, 1'b0);
        check("t1_expected", expected, 5'b00100);
        check("t1_pass", pass, 1'b1);
        check("t1_chk", chk_count, 8'd1);
        check("t1_err", err_count, 8'd0);
        txn(4'b1111, 4'b0001, 1'b0, 1'b0);
        check("t2_expected", expected, 5'b10000);
        check("t2_pass", pass, 1'b1);
        check("t2_chk", chk_count, 8'd2);
        txn(4'b1010, 4'b0100, 1'b1, 1'b1);
        check("t3_expected", expected, 5'b01111);
        check("t3_pass", pass, 1'b0);
        check("t3_err", err_count, 8'd1);
        check("t3_chk", chk_count, 8'd3);

        // Overrun: second set offered one edge after capture
        @(negedge clk);
        A = 4'd3; B = 4'd4; c0 = 1'b0; valid_in = 1'b1;
        @(negedge clk);
        A = 4'd9; B = 4'd9; c0 = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        check("t4_overrun", overrun, 1'b1);
        dones = 0;
        for (int i = 0; i < 7; i++) begin
            if (done) dones++;
            @(negedge clk);
        end
        check("t4_one_done", dones, 1);
        check("t4_expected", expected, 5'd7);
        check("t4_pass", pass, 1'b1);

        // Asynchronous reset while a check is pending
        @(negedge clk);
        A = 4'd5; B = 4'd6; c0 = 1'b0; valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        check("t5_busy_before", busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("t5_busy", busy, 1'b0);
        check("t5_done", done, 1'b0);
        check("t5_chk", chk_count, 8'd0);
        check("t5_err", err_count, 8'd0);
        check("t5_expected", expected, 5'd0);
        check("t5_overrun", overrun, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("t5_no_done", dones, 0);
        txn(4'd7, 4'd8, 1'b1, 1'b0);
        check("t5_next_expected", expected, 5'b10000);
        check("t5_next_chk", chk_count, 8'd1);
        check("t5_next_pass", pass, 1'b1);

        // Saturation: 260 back-to-back forced mismatches
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        force_err = 1'b1;
        for (int i = 0; i < 260; i++) begin
            @(negedge clk);
            if (i > 0) check("t6_done_period", done, 1'b1);
            A = W'($urandom); B = W'($urandom); c0 = 1'($urandom); valid_in = 1'b1;
            @(negedge clk);
            valid_in = 1'b0;
            check("t6_done_gap", done, 1'b0);
            @(negedge clk);
        end
        @(negedge clk);
        check("t6_done_last", done, 1'b1);
        check("t6_chk_sat", chk_count, 8'd255);
        check("t6_err_sat", err_count, 8'd255);
        force_err = 1'b0;

        // Random traffic against the model
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            valid_in  = ($urandom_range(0, 2) == 0);
            A         = W'($urandom);
            B         = W'($urandom);
            c0        = 1'($urandom);
            force_err = ($urandom_range(0, 3) == 0);
        end
        valid_in = 1'b0;
        force_err = 1'b0;
        repeat (5) @(negedge clk);
        checking = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/cla_result_checker.md
# cla_result_checker

- Synthesizable response checker for the carry-lookahead adder: the consuming end of the adder's A/B/c0 → S interface.
- Captures each operand set on a valid strobe, computes the golden sum, waits the adder's pipeline latency, then samples S and compares.
- Reports pass/fail and keeps running check, error and overrun counts.
- Sits next to the adder in the test harness and in on-chip self-test, replacing manual inspection of printed results.

## Interface

Parameters:
- WIDTH, 4: operand width; S and the golden sum are WIDTH+1 bits.
- LATENCY, 2: clock edges from operand capture to the edge at which S is valid. Legal range 1–15.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- valid_in  in  1  operands A/B/c0 are being presented to the adder this cycle.
- A  in  WIDTH  operand A, as driven to the adder.
- B  in  WIDTH  operand B, as driven to the adder.
- c0  in  1  carry-in, as driven to the adder.
- S  in  WIDTH+1  adder result, with carry-out in the MSB.
- busy  out  1  a check is pending; valid_in is not accepted.
- done  out  1  one-cycle pulse: a comparison completed.
- pass  out  1  result of the last comparison; held until the next done.
- expected  out  WIDTH+1  golden sum of the last accepted operand set.
- chk_count  out  8  comparisons completed, saturating at 255.
- err_count  out  8  failed comparisons, saturating at 255.
- overrun  out  1  sticky: valid_in was asserted while busy.

## Operation

- States: IDLE, WAIT.
- Reset values: state IDLE, busy 0, done 0, pass 0, expected 0, chk_count 0, err_count 0, overrun 0, latency counter 0.
- **IDLE.** If valid_in is high at an edge:
  - Capture the golden sum into expected: A + B + c0, computed zero-extended to WIDTH+1 bits, with no truncation of the carry.
  - Load the counter with LATENCY and go to WAIT.
- **WAIT.** The counter decrements at each edge. At the edge where the counter equals 1:
  - Sample S and set pass = (S == expected).
  - Increment chk_count.
  - If pass is 0, increment err_count.
  - Assert done for the following cycle and return to IDLE.
- **valid_in while in WAIT.**
  - The operands are ignored and the pending check is unaffected.
  - overrun is set and stays set until reset.
- **Counter saturation.** A counter at 255 holds at 255. err_count never exceeds chk_count.
- **Reset during WAIT.**
  - The pending check is discarded and no done is issued.
  - All outputs take their reset values at once; this is asynchronous.
- **Don't-care inputs.**
  - S is not examined outside the sample edge.
  - A, B and c0 are not examined unless valid_in is high in IDLE.

## Timing

- valid_in is accepted at edge k. busy is high in the cycles following edges k … k+LATENCY−1.
- S is sampled at edge k+LATENCY.
- done, pass and the updated counts are visible in the cycle after edge k+LATENCY. done is high for exactly that one cycle.
- busy is 0 in that same cycle, so the next valid_in can be accepted at edge k+LATENCY+1. Back-to-back throughput is one check per LATENCY+1 cycles.
- expected updates in the cycle after edge k and is stable through WAIT.
- With LATENCY = 1, S is sampled at the edge immediately following capture.

## Test plan

Use WIDTH = 4, LATENCY = 2, with the real adder connected unless noted.

1. A=0001, B=0010, c0=1 → expected=00100. After edge k+2: done pulse, pass=1, chk_count=1, err_count=0.
2. A=1111, B=0001, c0=0 → expected=10000, carry-out preserved. pass=1, chk_count=2.
3. A=1010, B=0100, c0=1 → expected=01111. Then force S=01110 at the sample edge → pass=0, err_count=1.
4. Assert valid_in at edge k and again at k+1 → second set ignored, overrun=1, expected unchanged, exactly one done.
5. Assert rst asynchronously between capture and the sample edge → busy/done/counts immediately 0, no done afterwards. The next transaction completes normally.
6. Run 260 back-to-back checks with forced mismatches → chk_count and err_count hold at 255. done occurs every 3 cycles.
